// File: rtl/fifo_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_ctrl
// Purpose  : Write-side pointer and flag controller for an async FIFO. It runs
//            entirely in the write clock domain. It owns the binary and grey
//            write pointers and drives the RAM write strobe and address. It
//            synchronises the read-domain grey pointer and produces the full,
//            almost-full and fill-level status.
// Ports    : clk              write-domain clock
//            reset            synchronous, active-high reset
//            wr_req_in        writer requests a push this cycle
//            rd_grey_ptr_in   read grey pointer (asynchronous to clk)
//            wr_en_out        RAM write strobe (accepted push)
//            wr_addr_out      RAM write address
//            wr_grey_ptr_out  registered write grey pointer for the read side
//            full_out         FIFO full, pushes refused
//            almost_full_out  fill level >= ALMOST_FULL_THRESH
//            wr_count_out     fill level seen from the write domain
//            overflow_out     sticky push-while-full flag (optional)
// Options  : define FIFO_OVERFLOW_DETECT_EN to add overflow_out and its logic.
// Revision : 1.0  initial release
// ============================================================================
module fifo_write_ctrl #(
  parameter int ADDR_WIDTH         = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req_in,
  input  logic [ADDR_WIDTH:0]   rd_grey_ptr_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [ADDR_WIDTH:0]   wr_grey_ptr_out,
  output logic                  full_out,
  output logic                  almost_full_out,
  output logic [ADDR_WIDTH:0]   wr_count_out
`ifdef FIFO_OVERFLOW_DETECT_EN
  ,
  output logic                  overflow_out
`endif
);

  localparam int               c_PW     = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_THRESH = c_PW'(ALMOST_FULL_THRESH);
  // Full means the write pointer is exactly one lap ahead of the read
  // pointer; in grey code that is the read pointer with its top two bits
  // inverted, which an XOR with this mask produces.
  localparam logic [ADDR_WIDTH:0] c_FULL_MASK = c_PW'(3) << (ADDR_WIDTH - 1);

  function automatic logic [ADDR_WIDTH:0] grey_to_binary(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] r_wr_bin;
  logic [ADDR_WIDTH:0] r_wr_grey;
  logic [ADDR_WIDTH:0] r_sync [SYNC_STAGES];

  logic                w_accept;
  logic [ADDR_WIDTH:0] w_bin_next;
  logic [ADDR_WIDTH:0] w_grey_next;
  logic [ADDR_WIDTH:0] w_rq_sync;
  logic [ADDR_WIDTH:0] w_rd_bin_sync;
  logic [ADDR_WIDTH:0] w_level;
  logic [ADDR_WIDTH:0] w_level_sat;

  assign w_accept      = wr_req_in & ~full_out;
  assign w_bin_next    = r_wr_bin + c_PW'(w_accept);
  assign w_grey_next   = w_bin_next ^ (w_bin_next >> 1);
  assign w_rq_sync     = r_sync[SYNC_STAGES-1];
  assign w_rd_bin_sync = grey_to_binary(w_rq_sync);
  // Modulo subtraction handles the pointer MSB rollover naturally.
  assign w_level       = w_bin_next - w_rd_bin_sync;
  // A level above the depth can only come from an inconsistent read pointer
  // (e.g. the read side not reset together with us); pin it to the depth.
  assign w_level_sat   = (w_level > c_DEPTH) ? c_DEPTH : w_level;

  assign wr_en_out       = w_accept;
  assign wr_addr_out     = r_wr_bin[ADDR_WIDTH-1:0];
  assign wr_grey_ptr_out = r_wr_grey;

  // Read pointer synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= rd_grey_ptr_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Pointers and registered status. Flags look at the post-push pointer so
  // full asserts on the same edge that takes the last free slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bin        <= '0;
      r_wr_grey       <= '0;
      full_out        <= 1'b0;
      almost_full_out <= 1'b0;
      wr_count_out    <= '0;
    end else begin
      r_wr_bin        <= w_bin_next;
      r_wr_grey       <= w_grey_next;
      full_out        <= (w_grey_next == (w_rq_sync ^ c_FULL_MASK));
      almost_full_out <= (w_level_sat >= c_THRESH);
      wr_count_out    <= w_level_sat;
    end
  end

`ifdef FIFO_OVERFLOW_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_out <= 1'b0;
    end else begin
      if (wr_req_in && full_out) begin
        overflow_out <= 1'b1;
      end
      assert (!(wr_req_in && full_out))
        else $warning("fifo_write_ctrl: push requested while full, data dropped");
    end
  end
`endif

endmodule
`default_nettype wire
